// File: rtl/render_pkg.sv
// Shared types for the render front end: colors, triangles, frame-sequencer states.
// The frame sequencer's optional watchdog is enabled with FRAME_SEQ_WATCHDOG_EN.
package render_pkg;

    localparam int FRAME_COUNT_W = 16;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } color12_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } vertex_t;

    typedef struct packed {
        vertex_t  v0;
        vertex_t  v1;
        vertex_t  v2;
        color12_t color;
    } triangle_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FILL_LOAD = 3'd1,
        ST_BEGIN     = 3'd2,
        ST_STREAM    = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_SWAP      = 3'd5,
        ST_DONE      = 3'd6
    } frame_seq_state_t;

endpackage

// File: rtl/render_frame_sequencer_if.sv
// Bundle of every handshake/bus signal around render_frame_sequencer.
// master = the sequencer's view, slave = host, triangle source, render manager and swap logic.
interface render_frame_sequencer_if;
    import render_pkg::*;

    color12_t                 cmd_fill_color;
    logic [15:0]              cmd_tri_count;
    logic                     cmd_valid;
    logic                     cmd_ready;

    triangle_t                tri_in;
    logic                     tri_in_valid;
    logic                     tri_in_ready;

    color12_t                 rm_fill_color;
    logic                     rm_fill_valid;
    logic                     rm_fill_ready;
    logic                     rm_begin_frame;
    triangle_t                rm_triangle;
    logic                     rm_triangle_valid;
    logic                     rm_triangle_ready;
    logic                     rm_busy;

    logic                     swap_req;
    logic                     swap_ack;

    logic                     frame_done;
    logic [FRAME_COUNT_W-1:0] frame_count;
    logic                     err_timeout;

    modport master (
        input  cmd_fill_color, cmd_tri_count, cmd_valid,
        input  tri_in, tri_in_valid,
        input  rm_fill_ready, rm_triangle_ready, rm_busy, swap_ack,
        output cmd_ready, tri_in_ready,
        output rm_fill_color, rm_fill_valid, rm_begin_frame,
        output rm_triangle, rm_triangle_valid,
        output swap_req, frame_done, frame_count, err_timeout
    );

    modport slave (
        output cmd_fill_color, cmd_tri_count, cmd_valid,
        output tri_in, tri_in_valid,
        output rm_fill_ready, rm_triangle_ready, rm_busy, swap_ack,
        input  cmd_ready, tri_in_ready,
        input  rm_fill_color, rm_fill_valid, rm_begin_frame,
        input  rm_triangle, rm_triangle_valid,
        input  swap_req, frame_done, frame_count, err_timeout
    );

endinterface

// File: rtl/frame_watchdog.sv
// No-progress watchdog for the frame sequencer; only built with FRAME_SEQ_WATCHDOG_EN.
// Counts cycles while run=1, restarts on clear, and pulses expired on the cycle the
// count reaches TIMEOUT_CYCLES.
`ifdef FRAME_SEQ_WATCHDOG_EN
module frame_watchdog #(
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam logic [31:0] LIMIT = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] cnt_q, cnt_d;

    // Fire on the TIMEOUT_CYCLES-th uninterrupted running cycle, then start over.
    always_comb begin
        expired = run && !clear && (cnt_q == LIMIT);
        if (clear || !run || expired) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Counter register, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/render_frame_sequencer.sv
// Per-frame controller in front of render_manager: command accept, fill-color load,
// begin_frame pulse, metered triangle pass-through, drain wait, buffer swap, completion.
// Optional no-progress watchdog enabled with FRAME_SEQ_WATCHDOG_EN.
module render_frame_sequencer
    import render_pkg::*;
#(
    parameter int MAX_TRIS    = 4096,
    parameter int DRAIN_QUIET = 2
`ifdef FRAME_SEQ_WATCHDOG_EN
    , parameter int TIMEOUT_CYCLES = 2_000_000
`endif
) (
    input logic                      clk,
    input logic                      rst,
    render_frame_sequencer_if.master bus
);

    localparam int REM_W = $clog2(MAX_TRIS + 1);
    localparam int DQ_W  = $clog2(DRAIN_QUIET + 1);
    localparam logic [REM_W-1:0] MAX_REM = REM_W'(MAX_TRIS);

    localparam logic [2:0] S_IDLE   = 3'(ST_IDLE);
    localparam logic [2:0] S_FILL   = 3'(ST_FILL_LOAD);
    localparam logic [2:0] S_BEGIN  = 3'(ST_BEGIN);
    localparam logic [2:0] S_STREAM = 3'(ST_STREAM);
    localparam logic [2:0] S_DRAIN  = 3'(ST_DRAIN);
    localparam logic [2:0] S_SWAP   = 3'(ST_SWAP);
    localparam logic [2:0] S_DONE   = 3'(ST_DONE);

    logic [2:0]               state_q, state_d, state_nat;
    logic [REM_W-1:0]         remaining_q, remaining_d;
    logic [DQ_W-1:0]          drain_q, drain_d, drain_nat;
    color12_t                 color_q, color_d;
    logic [FRAME_COUNT_W-1:0] frame_count_q, frame_count_d;
    logic                     tri_hs;

    assign tri_hs = (state_q == S_STREAM) && bus.tri_in_valid && bus.rm_triangle_ready;

    // Natural frame progression, before any watchdog override.
    always_comb begin
        state_nat     = state_q;
        remaining_d   = remaining_q;
        drain_nat     = drain_q;
        color_d       = color_q;
        frame_count_d = frame_count_q;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    color_d     = bus.cmd_fill_color;
                    remaining_d = (bus.cmd_tri_count > 16'(MAX_TRIS)) ? MAX_REM
                                                                      : REM_W'(bus.cmd_tri_count);
                    state_nat   = S_FILL;
                end
            end
            S_FILL: begin
                if (bus.rm_fill_ready) state_nat = S_BEGIN;
            end
            S_BEGIN: begin
                state_nat = (remaining_q != '0) ? S_STREAM : S_DRAIN;
            end
            S_STREAM: begin
                if (tri_hs) begin
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == REM_W'(1)) state_nat = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.rm_busy) begin
                    drain_nat = '0;
                end else if (drain_q == DQ_W'(DRAIN_QUIET - 1)) begin
                    drain_nat = '0;
                    state_nat = S_SWAP;
                end else begin
                    drain_nat = drain_q + 1'b1;
                end
            end
            S_SWAP: begin
                if (bus.swap_ack) state_nat = S_DONE;
            end
            S_DONE: begin
                frame_count_d = frame_count_q + 1'b1;
                state_nat     = S_IDLE;
            end
            default: state_nat = S_IDLE;
        endcase
    end

`ifdef FRAME_SEQ_WATCHDOG_EN
    logic err_q, err_d;
    logic wd_expired;
    logic wd_clear;
    logic wd_run;

    // Progress means a triangle moved or the FSM advanced on its own.
    assign wd_clear = tri_hs || (state_nat != state_q);
    assign wd_run   = (state_q == S_STREAM) || (state_q == S_DRAIN) || (state_q == S_SWAP);

    frame_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (wd_clear),
        .run    (wd_run),
        .expired(wd_expired)
    );

    // A timeout abandons the frame: force the swap, or skip it if already stuck there.
    always_comb begin
        state_d = state_nat;
        err_d   = err_q;
        if (wd_expired) begin
            err_d   = 1'b1;
            state_d = (state_q == S_SWAP) ? S_DONE : S_SWAP;
        end
    end

    // Sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err_timeout = err_q;
`else
    assign state_d         = state_nat;
    assign bus.err_timeout = 1'b0;
`endif

    // The quiet-cycle count only lives inside DRAIN.
    assign drain_d = (state_d == S_DRAIN) ? drain_nat : '0;

    // Frame state registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            remaining_q   <= '0;
            drain_q       <= '0;
            color_q       <= '0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            drain_q       <= drain_d;
            color_q       <= color_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Outputs decode straight from the state; triangles pass through only in STREAM.
    assign bus.cmd_ready         = (state_q == S_IDLE);
    assign bus.rm_fill_color     = color_q;
    assign bus.rm_fill_valid     = (state_q == S_FILL);
    assign bus.rm_begin_frame    = (state_q == S_BEGIN);
    assign bus.rm_triangle       = (state_q == S_STREAM) ? bus.tri_in : '0;
    assign bus.rm_triangle_valid = (state_q == S_STREAM) && bus.tri_in_valid;
    assign bus.tri_in_ready      = (state_q == S_STREAM) && bus.rm_triangle_ready;
    assign bus.swap_req          = (state_q == S_SWAP);
    assign bus.frame_done        = (state_q == S_DONE);
    assign bus.frame_count       = frame_count_q;

endmodule

// File: tb/tb_render_frame_sequencer.sv
// Self-checking bench for render_frame_sequencer: table of frame commands with
// hand-computed latencies/counts, plus hand-written reset-in-SWAP and (with
// FRAME_SEQ_WATCHDOG_EN) watchdog sequences.
module tb_render_frame_sequencer;
    import render_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    render_frame_sequencer_if bus();

`ifdef FRAME_SEQ_WATCHDOG_EN
    render_frame_sequencer #(.MAX_TRIS(4096), .DRAIN_QUIET(2), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst), .bus(bus.master));
`else
    render_frame_sequencer #(.MAX_TRIS(4096), .DRAIN_QUIET(2)) dut (
        .clk(clk), .rst(rst), .bus(bus.master));
`endif

    typedef struct {
        logic [11:0] color;
        int          count;
        int          push;
        int          ready_mode;   // 0: ready=1, 1: toggle 1/0 from STREAM start, 2: ready=0
        int          ack_mode;     // 0: tied 1, 1: one cycle after swap_req, 2: never
        bit          busy_arm;     // play busy 1,0,1,0,0 after the last triangle
        int          exp_fwd;
        int          exp_left;
        int          exp_fc;
        int          exp_swap;     // cycles from accept to first swap_req
        int          exp_lat;      // cycles from accept to next cmd_ready
    } row_t;

    row_t      rows [7];
    triangle_t tri_q[$];
    int        busy_q[$];
    int        cyc, accept_cyc, seq;
    bit        accepted_now, want_ready;
    int        fwd_cnt, begin_cnt, begin_cyc, fill_cyc, done_cnt, swap_cyc, ready_cyc, data_err;
    logic [11:0] fill_color;
    int        ready_mode, ack_mode;
    bit        busy_arm;
    logic      swap_prev;
    int        n_checks, n_pass;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic triangle_t mk_tri(input int s);
        triangle_t t;
        t.v0.x  = 10'(s);
        t.v0.y  = 10'(s * 3);
        t.v1.x  = 10'(s + 5);
        t.v1.y  = 10'(s >> 1);
        t.v2.x  = 10'(~s);
        t.v2.y  = 10'(s * 7);
        t.color = color12_t'(12'(s * 13));
        return t;
    endfunction

    // One clock cycle: drive models at the negedge, sample, then cross the posedge.
    task automatic tick();
        bit   hs;
        logic swap_now;
        int   rel;
        rel = cyc - accept_cyc;
        if (tri_q.size() > 0) begin
            bus.tri_in       = tri_q[0];
            bus.tri_in_valid = 1'b1;
        end else begin
            bus.tri_in       = '0;
            bus.tri_in_valid = 1'b0;
        end
        case (ready_mode)
            0:       bus.rm_triangle_ready = 1'b1;
            1:       bus.rm_triangle_ready = (rel % 2 == 1);
            default: bus.rm_triangle_ready = 1'b0;
        endcase
        case (ack_mode)
            0:       bus.swap_ack = 1'b1;
            1:       bus.swap_ack = swap_prev;
            default: bus.swap_ack = 1'b0;
        endcase
        bus.rm_busy = (busy_q.size() > 0) ? (busy_q[0] != 0) : 1'b0;
        #1;
        accepted_now = 1'b0;
        if (bus.cmd_valid && bus.cmd_ready) begin
            accepted_now = 1'b1;
            accept_cyc   = cyc;
        end
        if (bus.rm_fill_valid && fill_cyc < 0) begin
            fill_cyc   = cyc;
            fill_color = bus.rm_fill_color;
        end
        if (bus.rm_begin_frame) begin
            begin_cnt++;
            begin_cyc = cyc;
        end
        hs = bus.rm_triangle_valid && bus.rm_triangle_ready;
        if (hs) begin
            fwd_cnt++;
            if (tri_q.size() == 0 || bus.rm_triangle != tri_q[0] || !bus.tri_in_ready) data_err++;
        end
        if (bus.tri_in_ready && bus.tri_in_valid && !hs) data_err++;
        if (bus.swap_req && swap_cyc < 0) swap_cyc = cyc;
        if (bus.frame_done) done_cnt++;
        if (bus.cmd_ready && want_ready && ready_cyc < 0) ready_cyc = cyc;
        swap_now = bus.swap_req;
        @(posedge clk);
        if (hs) void'(tri_q.pop_front());
        if (busy_q.size() > 0) void'(busy_q.pop_front());
        if (hs && busy_arm && tri_q.size() == 0) busy_q = '{1, 0, 1, 0, 0};
        swap_prev = swap_now;
        cyc++;
        @(negedge clk);
    endtask

    task automatic clear_metrics();
        fwd_cnt = 0; begin_cnt = 0; done_cnt = 0; data_err = 0;
        fill_cyc = -1; begin_cyc = -1; swap_cyc = -1; ready_cyc = -1;
        want_ready = 1'b0;
    endtask

    // Issue one frame command and run until completion and the next cmd_ready.
    task automatic do_frame(input row_t r);
        int n;
        clear_metrics();
        ready_mode = r.ready_mode;
        ack_mode   = r.ack_mode;
        busy_arm   = r.busy_arm;
        for (int i = 0; i < r.push; i++) begin
            tri_q.push_back(mk_tri(seq));
            seq++;
        end
        bus.cmd_fill_color = color12_t'(r.color);
        bus.cmd_tri_count  = 16'(r.count);
        bus.cmd_valid      = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!accepted_now && n < 20);
        bus.cmd_valid = 1'b0;
        check("cmd_accept", int'(accepted_now), 1);
        want_ready = 1'b1;
        n = 0;
        while (done_cnt == 0 && n < 6000) begin
            tick();
            n++;
        end
        n = 0;
        while (ready_cyc < 0 && n < 5) begin
            tick();
            n++;
        end
    endtask

    initial begin
        rows[0] = '{12'h123,    3,    3, 0, 1, 1'b0,    3, 0, 1,    8,   11};
        rows[1] = '{12'hF00,    0,    0, 0, 0, 1'b0,    0, 0, 2,    5,    7};
        rows[2] = '{12'h0A5,    4,    6, 1, 1, 1'b0,    4, 2, 3,   12,   15};
        rows[3] = '{12'h3C3,    2,    0, 0, 1, 1'b0,    2, 0, 4,    7,   10};
        rows[4] = '{12'hFFF, 5000, 4100, 0, 1, 1'b0, 4096, 4, 5, 4101, 4104};
        rows[5] = '{12'h001,    4,    0, 0, 1, 1'b0,    4, 0, 6,    9,   12};
        rows[6] = '{12'h777,    1,    1, 0, 1, 1'b1,    1, 0, 7,    9,   12};

        n_checks = 0; n_pass = 0; cyc = 0; accept_cyc = 0; seq = 1;
        ready_mode = 0; ack_mode = 1; busy_arm = 1'b0; swap_prev = 1'b0;
        bus.cmd_fill_color = '0; bus.cmd_tri_count = '0; bus.cmd_valid = 1'b0;
        bus.tri_in = '0; bus.tri_in_valid = 1'b0;
        bus.rm_fill_ready = 1'b1; bus.rm_triangle_ready = 1'b1;
        bus.rm_busy = 1'b0; bus.swap_ack = 1'b0;
        clear_metrics();
        @(negedge clk);

        rst = 1'b0;
        repeat (3) tick();
        check("rst_cmd_ready",   int'(bus.cmd_ready), 1);
        check("rst_fill_valid",  int'(bus.rm_fill_valid), 0);
        check("rst_begin",       int'(bus.rm_begin_frame), 0);
        check("rst_tri_valid",   int'(bus.rm_triangle_valid), 0);
        check("rst_tri_ready",   int'(bus.tri_in_ready), 0);
        check("rst_swap_req",    int'(bus.swap_req), 0);
        check("rst_frame_done",  int'(bus.frame_done), 0);
        check("rst_frame_count", int'(bus.frame_count), 0);
        check("rst_err_timeout", int'(bus.err_timeout), 0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            do_frame(rows[i]);
            $display("frame %0d: count=%0d fwd=%0d left=%0d swap@%0d ready@%0d fc=%0d",
                     i, rows[i].count, fwd_cnt, tri_q.size(), swap_cyc - accept_cyc,
                     ready_cyc - accept_cyc, bus.frame_count);
            check($sformatf("f%0d_forwarded", i),  fwd_cnt, rows[i].exp_fwd);
            check($sformatf("f%0d_left", i),       tri_q.size(), rows[i].exp_left);
            check($sformatf("f%0d_data", i),       data_err, 0);
            check($sformatf("f%0d_begin_cnt", i),  begin_cnt, 1);
            check($sformatf("f%0d_begin_lat", i),  begin_cyc - accept_cyc, 2);
            check($sformatf("f%0d_fill_lat", i),   fill_cyc - accept_cyc, 1);
            check($sformatf("f%0d_fill_color", i), int'(fill_color), int'(rows[i].color));
            check($sformatf("f%0d_swap_lat", i),   swap_cyc - accept_cyc, rows[i].exp_swap);
            check($sformatf("f%0d_done_cnt", i),   done_cnt, 1);
            check($sformatf("f%0d_frame_count", i), int'(bus.frame_count), rows[i].exp_fc);
            check($sformatf("f%0d_ready_lat", i),  ready_cyc - accept_cyc, rows[i].exp_lat);
            check($sformatf("f%0d_err", i),        int'(bus.err_timeout), 0);
        end

        // Reset while holding swap_req: everything drops on the next cycle, no frame_done.
        begin
            int n;
            clear_metrics();
            ready_mode = 0; ack_mode = 2; busy_arm = 1'b0;
            bus.cmd_fill_color = color12_t'(12'h0F0);
            bus.cmd_tri_count  = 16'd0;
            bus.cmd_valid      = 1'b1;
            n = 0;
            do begin
                tick();
                n++;
            end while (!accepted_now && n < 20);
            bus.cmd_valid = 1'b0;
            n = 0;
            while (swap_cyc < 0 && n < 20) begin
                tick();
                n++;
            end
            tick();
            tick();
            check("rstswap_held", int'(bus.swap_req), 1);
            rst = 1'b0;
            tick();
            $display("reset in SWAP: swap_req=%0d fc=%0d cmd_ready=%0d done=%0d",
                     bus.swap_req, bus.frame_count, bus.cmd_ready, done_cnt);
            check("rstswap_swap_req",    int'(bus.swap_req), 0);
            check("rstswap_frame_count", int'(bus.frame_count), 0);
            check("rstswap_err",         int'(bus.err_timeout), 0);
            check("rstswap_cmd_ready",   int'(bus.cmd_ready), 1);
            check("rstswap_frame_done",  int'(bus.frame_done), 0);
            check("rstswap_no_done",     done_cnt, 0);
            rst = 1'b1;
            ack_mode = 1;
            tick();
        end

`ifdef FRAME_SEQ_WATCHDOG_EN
        // Stalled stream: after 100 cycles without progress the frame is force-swapped.
        begin
            row_t wr;
            wr = '{12'h456, 2, 2, 2, 1, 1'b0, 0, 2, 1, 103, 106};
            do_frame(wr);
            $display("watchdog: fwd=%0d swap@%0d err=%0d done=%0d fc=%0d",
                     fwd_cnt, swap_cyc - accept_cyc, bus.err_timeout, done_cnt, bus.frame_count);
            check("wd_forwarded",  fwd_cnt, wr.exp_fwd);
            check("wd_swap_lat",   swap_cyc - accept_cyc, wr.exp_swap);
            check("wd_err",        int'(bus.err_timeout), 1);
            check("wd_done_cnt",   done_cnt, 1);
            check("wd_frame_count", int'(bus.frame_count), wr.exp_fc);
            check("wd_left",       tri_q.size(), wr.exp_left);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/render_frame_sequencer.md
# render_frame_sequencer

Per-frame controller in front of `render_manager`. It accepts one frame command (clear color plus triangle count) from the host/command decoder, loads the fill color, and pulses `begin_frame`. It then meters exactly the commanded number of triangles from the upstream triangle source into the render manager, waits for the pipeline to drain, and performs a framebuffer swap handshake. It reports completion and keeps a frame counter.

## Interface
- `MAX_TRIS`, 4096: largest accepted `cmd_tri_count`; larger values are clamped to this.
- `DRAIN_QUIET`, 2: consecutive cycles `rm_busy` must be low before drain is complete.
- `TIMEOUT_CYCLES`, 2_000_000: watchdog limit in cycles without progress (used only with the watchdog enabled).

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous reset, active-low.
- `cmd_fill_color` in `color12_t`: frame clear color.
- `cmd_tri_count` in 16: triangles in the frame.
- `cmd_valid` in 1 / `cmd_ready` out 1: frame command handshake.
- `tri_in` in `triangle_t`, `tri_in_valid` in 1, `tri_in_ready` out 1: upstream triangle stream.
- `rm_fill_color` out `color12_t`, `rm_fill_valid` out 1, `rm_fill_ready` in 1: to render manager.
- `rm_begin_frame` out 1: one-cycle pulse.
- `rm_triangle` out `triangle_t`, `rm_triangle_valid` out 1, `rm_triangle_ready` in 1.
- `rm_busy` in 1: render manager busy.
- `swap_req` out 1 / `swap_ack` in 1: framebuffer swap handshake.
- `frame_done` out 1: one-cycle pulse after the swap completes.
- `frame_count` out 16: completed frames, wraps at 0xFFFF→0.
- `err_timeout` out 1: sticky watchdog flag.

## Operation
- States: IDLE, FILL_LOAD, BEGIN, STREAM, DRAIN, SWAP, DONE.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`: latch color and `min(cmd_tri_count, MAX_TRIS)` into `remaining`, then go to FILL_LOAD.
- **FILL_LOAD**
  - `rm_fill_valid`=1 with the latched color.
  - Go to BEGIN on the first cycle where `rm_fill_ready`=1.
- **BEGIN**
  - `rm_begin_frame`=1 for exactly one cycle.
  - Go to STREAM if `remaining`≠0, else go to DRAIN.
- **STREAM**
  - Combinational pass-through:
    - `rm_triangle`=`tri_in`.
    - `rm_triangle_valid`=`tri_in_valid`.
    - `tri_in_ready`=`rm_triangle_ready`.
  - `remaining` decrements on each `tri_in_valid && rm_triangle_ready`.
  - When the handshake that takes `remaining` from 1 to 0 occurs, go to DRAIN.
- **DRAIN**
  - Count consecutive cycles with `rm_busy`=0; reset the count on any busy cycle.
  - When the count reaches `DRAIN_QUIET`, go to SWAP.
- **SWAP**
  - `swap_req`=1, held until the cycle `swap_ack`=1; then go to DONE.
  - `swap_ack` in other states is ignored.
- **DONE**
  - `frame_done`=1 and `frame_count`++.
  - Go to IDLE.
- Outside STREAM: `tri_in_ready`=0 and `rm_triangle_valid`=0. `rm_triangle` may be driven with `tri_in`.
- Extra upstream triangles beyond the count are not consumed. They remain for the next frame.
- `cmd_valid` outside IDLE is not accepted; it is held by the requester.

## Timing
- Reset (`rst`=0 at a clock edge), from any state:
  - State goes to IDLE and `remaining`, the drain counter and `frame_count` go to 0.
  - `err_timeout` goes to 0, as does the watchdog counter.
  - All outputs go to 0, except `cmd_ready`, which is 1 in the first cycle after reset.
  - Mid-frame reset drops `swap_req` immediately; no `frame_done`.
- Command accept to `rm_fill_valid`: 1 cycle.
- With `rm_fill_ready` tied 1, `rm_begin_frame` asserts 2 cycles after the command accept.
- STREAM adds 0 cycles of latency and sustains 1 triangle/cycle.
- Minimum frame with count 0 and `swap_ack` tied 1 runs IDLE→FILL_LOAD→BEGIN→DRAIN(×2)→SWAP→DONE→IDLE, so the next `cmd_ready` comes 7 cycles after the accept.
- `frame_count` updates on the same edge that `frame_done` is high.
- `cmd_tri_count` > `MAX_TRIS`: clamp; no error.

## Configuration
- `FRAME_SEQ_WATCHDOG_EN` defined:
  - A 32-bit counter runs in STREAM, DRAIN and SWAP.
  - It clears on every triangle handshake and on each state change.
  - On reaching `TIMEOUT_CYCLES`:
    - Set `err_timeout` (sticky until reset).
    - Force the state to SWAP; from DRAIN or STREAM this abandons the remaining triangles.
    - If already in SWAP, drop `swap_req` and go to DONE.
    - `frame_done` still pulses.
- Not defined: no counter; `err_timeout` is tied 0 and states wait indefinitely.

## Structure
- `render_pkg` holds `triangle_t`, `color12_t`, `frame_seq_state_t` (3-bit enum) and `FRAME_COUNT_W`=16.
- One sub-module, `frame_watchdog`, compiled only under the macro. It takes `clear`, `run`, and the `TIMEOUT_CYCLES` parameter, and outputs an `expired` pulse.

## Test plan
- Count 3, `rm_triangle_ready`=1, `swap_ack` 1 cycle after `swap_req`:
  - Exactly 3 triangles are forwarded and `begin_frame` pulses once.
  - `frame_done` pulses once and `frame_count` goes 0→1.
- Count 0:
  - No triangle handshakes.
  - Fill color 0xF00 appears on `rm_fill_color` with `rm_fill_valid`.
  - The swap completes and the next `cmd_ready` comes 7 cycles after the accept.
- Count 4, 6 triangles queued upstream, `rm_triangle_ready` toggling 1/0:
  - 4 are consumed and 2 are still pending after `frame_done`.
  - A second command with count 2 consumes those 2.
- Count 1, then `rm_busy` pattern 1,0,1,0,0:
  - SWAP is entered only after the final two consecutive zeros.
- Reset asserted in SWAP with `swap_req`=1:
  - Next cycle `swap_req`=0, `frame_count` and `err_timeout`=0, `cmd_ready`=1, no `frame_done`.
- `FRAME_SEQ_WATCHDOG_EN` with `TIMEOUT_CYCLES`=100, count 2, `rm_triangle_ready` held 0:
  - After 100 idle cycles, `err_timeout`=1 and `swap_req` asserts.
  - After the swap, `frame_done` pulses.
